// File: rtl/key_event_arbiter_pkg.sv
// Shared definitions for the keyboard event arbiter: source ids, code width, code prefixes
// and the round-robin successor helper.
package key_event_arbiter_pkg;

    localparam int unsigned NUM_SRC   = 3;
    localparam int unsigned EV_CODE_W = 8;

    localparam logic [1:0] SRC_KEY = 2'd0;
    localparam logic [1:0] SRC_ENC = 2'd1;
    localparam logic [1:0] SRC_PAT = 2'd2;

    localparam logic [EV_CODE_W-1:0] EV_DROP_MARKER = 8'h00;

    localparam logic [1:0] KEY_PRESS_PFX   = 2'b10;
    localparam logic [1:0] KEY_RELEASE_PFX = 2'b01;
    localparam logic [1:0] ENC_PFX         = 2'b11;

    // Round-robin successor in key -> enc -> pat -> key order.
    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == SRC_PAT) ? SRC_KEY : s + 2'd1;
    endfunction

endpackage

// File: rtl/key_event_arbiter_if.sv
// Event-source pulses plus the host-facing valid/ack event channel and status.
// The arbiter uses the slave modport; the source/host side uses master.
interface key_event_arbiter_if #(
    parameter int unsigned PTR_W  = 3,
    parameter int unsigned DROP_W = 8
);
    import key_event_arbiter_pkg::*;

    logic                 key_ev_rdy;
    logic [EV_CODE_W-1:0] key_code;
    logic                 enc_ev_rdy;
    logic [EV_CODE_W-1:0] enc_code;
    logic                 pat_ev_rdy;
    logic [EV_CODE_W-1:0] pat_code;
    logic                 ev_valid;
    logic [EV_CODE_W-1:0] ev_code;
    logic                 ev_ack;
    logic [PTR_W:0]       fifo_level;
    logic [DROP_W-1:0]    drop_cnt;

    modport master (
        output key_ev_rdy, key_code, enc_ev_rdy, enc_code, pat_ev_rdy, pat_code, ev_ack,
        input  ev_valid, ev_code, fifo_level, drop_cnt
    );

    modport slave (
        input  key_ev_rdy, key_code, enc_ev_rdy, enc_code, pat_ev_rdy, pat_code, ev_ack,
        output ev_valid, ev_code, fifo_level, drop_cnt
    );

endinterface

// File: rtl/key_event_arbiter_fifo.sv
// Show-ahead synchronous event FIFO; push and pop may coincide at any level including full.
module key_event_arbiter_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PTR_W  = 3,
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_valid,
    output logic              o_full,
    output logic [PTR_W:0]    o_level
);

    localparam logic [PTR_W:0]   FULL_LVL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W+1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_level;
    logic              w_pop;
    logic              w_push;

    assign o_valid = (r_level != '0);
    assign o_full  = (r_level == FULL_LVL);
    assign o_level = r_level;
    assign w_pop   = i_pop & o_valid;
    assign w_push  = i_push & (~o_full | w_pop);
    // Drive zero while empty so the host never sees a stale code.
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/key_event_arbiter.sv
// Pending slots for key/encoder/patient sources, round-robin grant into the event FIFO,
// saturating drop counter. Optional drop marker requester: KEV_DROP_MARKER_EN.
module key_event_arbiter
    import key_event_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PTR_W      = 3,
    parameter int unsigned DROP_W     = 8
) (
    input logic               i_clk,
    input logic               i_rst_n,
    key_event_arbiter_if.slave io_bus
);

    logic [NUM_SRC-1:0]   w_pulse;
    logic [EV_CODE_W-1:0] w_in_code [NUM_SRC];
    logic [NUM_SRC-1:0]   r_pend;
    logic [EV_CODE_W-1:0] r_code [NUM_SRC];
    logic [1:0]           r_last;
    logic [DROP_W-1:0]    r_drop;

    logic                 w_valid;
    logic                 w_full;
    logic                 w_can_push;
    logic                 w_found;
    logic [1:0]           w_src;
    logic [1:0]           w_cand;
    logic [NUM_SRC-1:0]   w_grant;
    logic [NUM_SRC-1:0]   w_drop;
    logic [1:0]           w_drop_n;
    logic [DROP_W:0]      w_drop_sum;
    logic [DROP_W-1:0]    w_drop_next;
    logic                 w_mark_grant;
    logic                 w_push;
    logic [EV_CODE_W-1:0] w_push_code;

    assign w_pulse[SRC_KEY]   = io_bus.key_ev_rdy;
    assign w_pulse[SRC_ENC]   = io_bus.enc_ev_rdy;
    assign w_pulse[SRC_PAT]   = io_bus.pat_ev_rdy;
    assign w_in_code[SRC_KEY] = io_bus.key_code;
    assign w_in_code[SRC_ENC] = io_bus.enc_code;
    assign w_in_code[SRC_PAT] = io_bus.pat_code;

    // A pop this cycle frees a slot even when full, so push and pop can coincide.
    assign w_can_push = ~w_full | (w_valid & io_bus.ev_ack);

    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_src   = r_last;
        w_cand  = r_last;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_cand = next_src(w_cand);
            if (!w_found && r_pend[w_cand]) begin
                w_found = 1'b1;
                w_src   = w_cand;
            end
        end
        if (w_found && w_can_push) begin
            w_grant[w_src] = 1'b1;
        end
    end

    assign w_drop = w_pulse & r_pend & ~w_grant;

    always_comb begin
        w_drop_n = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            w_drop_n = w_drop_n + 2'(w_drop[s]);
        end
        w_drop_sum  = {1'b0, r_drop} + (DROP_W+1)'(w_drop_n);
        w_drop_next = w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
    end

`ifdef KEV_DROP_MARKER_EN
    logic r_marker;

    // Marker sits below every source slot and does not move the round-robin pointer.
    assign w_mark_grant = r_marker & ~w_found & w_can_push;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_marker <= 1'b0;
        end else if (|w_drop) begin
            r_marker <= 1'b1;
        end else if (w_mark_grant) begin
            r_marker <= 1'b0;
        end
    end
`else
    assign w_mark_grant = 1'b0;
`endif

    assign w_push      = (|w_grant) | w_mark_grant;
    assign w_push_code = w_mark_grant ? EV_DROP_MARKER : r_code[w_src];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= '0;
            r_last <= SRC_PAT;
            r_drop <= '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                r_code[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (w_pulse[s] && !w_drop[s]) begin
                    r_pend[s] <= 1'b1;
                    r_code[s] <= w_in_code[s];
                end else if (w_grant[s]) begin
                    r_pend[s] <= 1'b0;
                end
            end
            if (|w_grant) begin
                r_last <= w_src;
            end
            r_drop <= w_drop_next;
        end
    end

    key_event_arbiter_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .PTR_W  (PTR_W),
        .DATA_W (EV_CODE_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (w_push_code),
        .i_pop   (io_bus.ev_ack),
        .o_head  (io_bus.ev_code),
        .o_valid (w_valid),
        .o_full  (w_full),
        .o_level (io_bus.fifo_level)
    );

    assign io_bus.ev_valid = w_valid;
    assign io_bus.drop_cnt = r_drop;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Scoreboard bench for key_event_arbiter: expected codes queued at stimulus time, compared on pop.
module tb_key_event_arbiter;
    import key_event_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    key_event_arbiter_if #(.PTR_W(3), .DROP_W(8)) bus ();

    key_event_arbiter #(
        .FIFO_DEPTH (8),
        .PTR_W      (3),
        .DROP_W     (8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [7:0]  sb [$];
    logic [1:0]  m_last;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] mask, input logic [7:0] ck, input logic [7:0] ce,
                         input logic [7:0] cp);
        bus.key_ev_rdy = mask[0];
        bus.enc_ev_rdy = mask[1];
        bus.pat_ev_rdy = mask[2];
        bus.key_code   = ck;
        bus.enc_code   = ce;
        bus.pat_code   = cp;
        tick();
        bus.key_ev_rdy = 1'b0;
        bus.enc_ev_rdy = 1'b0;
        bus.pat_ev_rdy = 1'b0;
    endtask

    // Expected grant order for three simultaneous pulses starts after the last grant.
    task automatic burst(input logic [7:0] ck, input logic [7:0] ce, input logic [7:0] cp);
        logic [7:0] c [3];
        logic [1:0] s;
        c[0] = ck;
        c[1] = ce;
        c[2] = cp;
        s = m_last;
        for (int i = 0; i < 3; i++) begin
            s = (s == 2'd2) ? 2'd0 : s + 2'd1;
            sb.push_back(c[s]);
        end
        drive(3'b111, ck, ce, cp);
    endtask

    task automatic ack_one(input string tag);
        int n;
        n = 0;
        while (!bus.ev_valid && n < 50) begin
            tick();
            n++;
        end
        if (!bus.ev_valid) begin
            check_eq({tag, "_valid_timeout"}, 32'(bus.ev_valid), 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            check_eq({tag, "_unexpected_event"}, 32'(bus.ev_valid), 32'd0);
        end else begin
            check_eq(tag, 32'(bus.ev_code), 32'(sb.pop_front()));
        end
        bus.ev_ack = 1'b1;
        tick();
        bus.ev_ack = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (sb.size() > 0) ack_one(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        bus.key_ev_rdy = 1'b0;
        bus.enc_ev_rdy = 1'b0;
        bus.pat_ev_rdy = 1'b0;
        bus.key_code   = '0;
        bus.enc_code   = '0;
        bus.pat_code   = '0;
        bus.ev_ack     = 1'b0;
        m_last         = 2'd2;
        tick();
        tick();
        check_eq("rst_valid", 32'(bus.ev_valid), 32'd0);
        check_eq("rst_code", 32'(bus.ev_code), 32'h00);
        check_eq("rst_level", 32'(bus.fifo_level), 32'd0);
        check_eq("rst_drop", 32'(bus.drop_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Triple burst from reset: keys first.
        burst(8'h41, 8'hC3, 8'h20);
        drain("burst1");
        check_eq("burst1_drop", 32'(bus.drop_cnt), 32'd0);

        // Single key event latency and pop.
        sb.push_back(8'h85);
        drive(3'b001, 8'h85, 8'h00, 8'h00);
        m_last = 2'd0;
        check_eq("single_lat_edgeN", 32'(bus.ev_valid), 32'd0);
        tick();
        check_eq("single_valid", 32'(bus.ev_valid), 32'd1);
        check_eq("single_level1", 32'(bus.fifo_level), 32'd1);
        ack_one("single_code");
        check_eq("single_level0", 32'(bus.fifo_level), 32'd0);
        check_eq("single_valid0", 32'(bus.ev_valid), 32'd0);

        // Pointer now at key: next burst starts at encoder.
        burst(8'h41, 8'hC3, 8'h20);
        drain("burst2");
        check_eq("burst2_drop", 32'(bus.drop_cnt), 32'd0);

        // Fill the FIFO with no acks; the ninth code waits in the slot, two are dropped.
        for (int i = 0; i < 11; i++) begin
            if (i < 9) sb.push_back(8'h10 + 8'(i));
            drive(3'b001, 8'h10 + 8'(i), 8'h00, 8'h00);
            tick();
        end
        m_last = 2'd0;
`ifdef KEV_DROP_MARKER_EN
        sb.push_back(EV_DROP_MARKER);
`endif
        tick();
        tick();
        check_eq("full_level", 32'(bus.fifo_level), 32'd8);
        check_eq("full_drop", 32'(bus.drop_cnt), 32'd2);
        ack_one("full_first");
        check_eq("full_pushpop_level", 32'(bus.fifo_level), 32'd8);
        drain("full_drain");
        tick();
        tick();
        check_eq("full_empty_valid", 32'(bus.ev_valid), 32'd0);
        check_eq("full_empty_level", 32'(bus.fifo_level), 32'd0);

        // Asynchronous reset with five queued events.
        for (int i = 0; i < 5; i++) begin
            drive(3'b001, 8'h60 + 8'(i), 8'h00, 8'h00);
            tick();
        end
        tick();
        check_eq("q5_level", 32'(bus.fifo_level), 32'd5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(bus.ev_valid), 32'd0);
        check_eq("arst_level", 32'(bus.fifo_level), 32'd0);
        check_eq("arst_drop", 32'(bus.drop_cnt), 32'd0);
        check_eq("arst_code", 32'(bus.ev_code), 32'h00);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        m_last = 2'd2;
        tick();
        sb.push_back(8'h5A);
        drive(3'b001, 8'h5A, 8'h00, 8'h00);
        m_last = 2'd0;
        drain("post_rst");
        check_eq("post_rst_drop", 32'(bus.drop_cnt), 32'd0);

        // Pulse on a slot that is pending but not granted that cycle.
        burst(8'hA1, 8'hB2, 8'hC3);
        case (m_last)
            2'd0:    drive(3'b001, 8'h77, 8'h00, 8'h00);
            2'd1:    drive(3'b010, 8'h00, 8'h77, 8'h00);
            default: drive(3'b100, 8'h00, 8'h00, 8'h77);
        endcase
`ifdef KEV_DROP_MARKER_EN
        sb.push_back(EV_DROP_MARKER);
`endif
        drain("drop_pend");
        check_eq("drop_pend_cnt", 32'(bus.drop_cnt), 32'd1);
        tick();
        tick();
        tick();
        check_eq("drop_pend_no_extra", 32'(bus.ev_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
